// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (bit count, receiver state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for an asynchronous input, resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver with mid-bit sampling and start-glitch
//               rejection. Define UART_RX_PARITY_EN for 8 data + parity + stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 40,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial,
    output logic [7:0] data,
    output logic       data_strobe,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int                  c_baud_w    = $clog2(DIVISOR);
    localparam int                  c_bit_w     = $clog2(UART_DATA_BITS);
    localparam logic [c_baud_w-1:0] c_half_load = c_baud_w'(DIVISOR / 2 - 1);
    localparam logic [c_baud_w-1:0] c_full_load = c_baud_w'(DIVISOR - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(UART_DATA_BITS - 1);

    if (DIVISOR < 4 || (DIVISOR % 2) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_rx: DIVISOR must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    logic                      w_rxs;
    logic                      w_tick;
    rx_state_t                 r_state,  w_state;
    logic [c_baud_w-1:0]       r_baud,   w_baud;
    logic [c_bit_w-1:0]        r_bit,    w_bit;
    logic [UART_DATA_BITS-1:0] r_shift,  w_shift;
    logic [7:0]                r_data,   w_data;
    logic                      r_strobe, w_strobe;
    logic                      r_ferr,   w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                      r_par,    w_par;
    logic                      r_perr,   w_perr;
    logic                      w_par_ok;

    assign w_par_ok = (r_par == ((^r_shift) ^ (PARITY_ODD != 0)));
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (serial),
        .o_q (w_rxs)
    );

    assign w_tick = (r_baud == '0);

    always_comb begin
        w_state  = r_state;
        w_baud   = r_baud;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_data   = r_data;
        w_strobe = 1'b0;
        w_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par    = r_par;
        w_perr   = 1'b0;
`endif
        if (r_state != IDLE && r_state != BREAK && !w_tick) begin
            w_baud = r_baud - c_baud_w'(1);
        end

        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state = START;
                    w_baud  = c_half_load;
                end
            end
            START: begin
                // A start bit that is already high again at mid-bit was a glitch.
                if (w_tick) begin
                    if (!w_rxs) begin
                        w_state = DATA;
                        w_bit   = '0;
                        w_baud  = c_full_load;
                    end else begin
                        w_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    w_baud  = c_full_load;
                    w_bit   = r_bit + c_bit_w'(1);
                    if (r_bit == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
                        w_state = PARITY;
`else
                        w_state = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_tick) begin
                    w_par   = w_rxs;
                    w_baud  = c_full_load;
                    w_state = STOP;
                end
`else
                w_state = IDLE;
`endif
            end
            STOP: begin
                // Leaving at mid-stop lets a directly following start bit be caught.
                if (w_tick) begin
                    if (w_rxs) begin
                        w_state = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (w_par_ok) begin
                            w_data   = r_shift;
                            w_strobe = 1'b1;
                        end else begin
                            w_perr   = 1'b1;
                        end
`else
                        w_data   = r_shift;
                        w_strobe = 1'b1;
`endif
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_baud   <= w_baud;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_data   <= w_data;
            r_strobe <= w_strobe;
            r_ferr   <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_par    <= w_par;
            r_perr   <= w_perr;
`endif
        end
    end

    assign data          = r_data;
    assign data_strobe   = r_strobe;
    assign framing_error = r_ferr;
    assign busy          = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_perr;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx; a line-level frame decoder
//               predicts every strobe/error from the recorded serial waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int D    = 40;
    localparam int H    = D / 2;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int NBITS = 10 + PAR;
    localparam int SPAN  = H + (9 + PAR) * D;  // start edge to stop-bit middle
    localparam int LAT   = SPAN + 3;           // 2 sync flops + 1 registered output
    localparam int MAXC  = 50000;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial;
    logic [7:0] data;
    logic       data_strobe;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    uart_rx #(.DIVISOR(D), .PARITY_ODD(PODD)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial        (serial),
        .data          (data),
        .data_strobe   (data_strobe),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int kind; logic [7:0] v; } ev_t;  // kind 0 strobe, 1 ferr, 2 perr

    int         cyc = 0;
    bit         line [MAXC];
    ev_t        dut_q[$];
    ev_t        mdl_q[$];
    int         n_str = 0, n_fe = 0, n_pe = 0, n_busy = 0;
    int         n_cmp = 0, n_bad = 0;
    int         rst_edge = 0;
    logic [7:0] model_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int near(input int got, input int exp);
        return (got >= exp - 1 && got <= exp + 1) ? exp : got;
    endfunction

    // line[k] is the level driven just after edge k
    always @(posedge clk) begin
        if (cyc < MAXC) line[cyc] = serial;
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        if (data_strobe)   begin dut_q.push_back('{c: cyc, kind: 0, v: data}); n_str++; end
        if (framing_error) begin dut_q.push_back('{c: cyc, kind: 1, v: data}); n_fe++;  end
        if (parity_error)  begin dut_q.push_back('{c: cyc, kind: 2, v: data}); n_pe++;  end
        if (data_strobe || framing_error || parity_error)
            check("pulse_excl", int'(data_strobe) + int'(framing_error) + int'(parity_error), 1);
        if (busy) n_busy++;
    end

    // All drive tasks are entered and left 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        serial = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, output int t0);
        t0 = cyc;
        drive_bit(1'b0, D);
        for (int i = 0; i < 8; i++) drive_bit(b[i], D);
        if (PAR != 0) drive_bit((^b) ^ (PODD != 0) ^ !par_ok, D);
        drive_bit(stop_ok, D);
    endtask

    task automatic pulse_reset();
        rst_edge = cyc + 1;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
    endtask

    function automatic bit ln(input int i);
        return (i < 0 || i >= MAXC) ? 1'b1 : line[i];
    endfunction

    // Walk the waveform frame by frame: a low level while idle is a start
    // candidate, confirmed half a bit later, then bits are read at their middles.
    task automatic model(input int from, input int lim);
        int         k;
        int         m;
        logic [7:0] b;
        bit         p_ok;
        k = from;
        while (1) begin
            while (k + 3 < lim && ln(k)) k++;
            if (k + 3 >= lim) break;
            if (ln(k + H)) begin k = k + H + 1; continue; end
            if (k + LAT >= lim) break;
            for (int i = 0; i < 8; i++) b[i] = ln(k + H + (i + 1) * D);
            p_ok = 1'b1;
            if (PAR != 0) p_ok = (ln(k + H + 9 * D) == ((^b) ^ (PODD != 0)));
            if (ln(k + SPAN)) begin
                if (p_ok) begin
                    model_data = b;
                    mdl_q.push_back('{c: k + LAT, kind: 0, v: b});
                end else begin
                    mdl_q.push_back('{c: k + LAT, kind: 2, v: model_data});
                end
                k = k + SPAN + 1;
            end else begin
                mdl_q.push_back('{c: k + LAT, kind: 1, v: model_data});
                m = k + SPAN + 1;
                while (m + 3 < lim && !ln(m)) m++;
                k = m + 1;
            end
        end
    endtask

    initial begin
        int t0, s0, f0, p0, b0, q0, cnt, n, lim_end;
        reset  = 1'b1;
        serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_data",   data, 8'h00);
        check("rst_strobe", data_strobe, 0);
        check("rst_ferr",   framing_error, 0);
        check("rst_perr",   parity_error, 0);
        check("rst_busy",   busy, 0);

        // Single frame after a long idle
        drive_bit(1'b1, 100);
        s0 = n_str;
        send_frame(8'h55, 1, 1, t0);
        drive_bit(1'b1, 2 * D);
        check("f55_count", n_str - s0, 1);
        check("f55_data",  data, 8'h55);
        check("f55_lat",   near(dut_q[dut_q.size() - 1].c - t0, LAT), LAT);
        check("f55_busy",  busy, 0);

        // Back-to-back frames with no idle gap
        s0 = n_str;
        send_frame(8'h00, 1, 1, t0);
        send_frame(8'hFF, 1, 1, t0);
        send_frame(8'hA5, 1, 1, t0);
        drive_bit(1'b1, 2 * D);
        n = dut_q.size();
        check("b2b_count", n_str - s0, 3);
        check("b2b_d0",    dut_q[n - 3].v, 8'h00);
        check("b2b_d1",    dut_q[n - 2].v, 8'hFF);
        check("b2b_d2",    dut_q[n - 1].v, 8'hA5);
        check("b2b_gap",   near(dut_q[n - 1].c - dut_q[n - 2].c, NBITS * D), NBITS * D);

        // Short low glitch
        s0 = n_str; f0 = n_fe; b0 = n_busy;
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 3 * D);
        check("gl_strobe", n_str - s0, 0);
        check("gl_ferr",   n_fe - f0, 0);
        check("gl_busy",   near(n_busy - b0, H), H);

        // Stop bit low followed by a long break, then a good frame
        s0 = n_str; f0 = n_fe;
        send_frame(8'h3C, 0, 1, t0);
        drive_bit(1'b0, 2000);
        check("brk_ferr",   n_fe - f0, 1);
        check("brk_strobe", n_str - s0, 0);
        check("brk_data",   data, 8'hA5);
        drive_bit(1'b1, 2 * D);
        send_frame(8'h81, 1, 1, t0);
        drive_bit(1'b1, 2 * D);
        check("brk_next",   data, 8'h81);
        check("brk_count",  n_str - s0, 1);

`ifdef UART_RX_PARITY_EN
        s0 = n_str; p0 = n_pe;
        send_frame(8'h07, 1, 1, t0);
        drive_bit(1'b1, 2 * D);
        check("par_ok_strobe", n_str - s0, 1);
        check("par_ok_data",   data, 8'h07);
        s0 = n_str;
        send_frame(8'h07, 1, 0, t0);
        drive_bit(1'b1, 2 * D);
        check("par_bad_perr",   n_pe - p0, 1);
        check("par_bad_strobe", n_str - s0, 0);
        check("par_bad_data",   data, 8'h07);
`endif

        // Reset pulse in the middle of data bit 4. The frame's low bit 7 then
        // looks like a fresh start bit to the re-armed receiver; the model covers it.
        drive_bit(1'b1, 50);
        f0 = n_fe; p0 = n_pe; q0 = dut_q.size();
        fork
            send_frame(8'h7E, 1, 1, t0);
            begin
                repeat (5 * D + H) @(posedge clk);
                #1;
                pulse_reset();
            end
        join
        drive_bit(1'b1, 12 * D);
        send_frame(8'h12, 1, 1, t0);
        drive_bit(1'b1, 2 * D);
        cnt = 0;
        for (int i = q0; i < dut_q.size(); i++)
            if (dut_q[i].kind == 0 && dut_q[i].v == 8'h7E) cnt++;
        check("rst_no7e",  cnt, 0);
        check("rst_errs",  (n_fe - f0) + (n_pe - p0), 0);
        check("rst_next",  data, 8'h12);

        // Random traffic: random bytes, gaps, glitches, bad stop/parity bits
        for (int it = 0; it < 30; it++) begin
            logic [7:0] b;
            bit         st_ok, p_ok;
            b     = 8'($urandom);
            st_ok = ($urandom_range(0, 7) != 0);
            p_ok  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                drive_bit(1'b0, $urandom_range(1, H - 4));
                drive_bit(1'b1, D);
            end
            send_frame(b, st_ok, p_ok, t0);
            if (!st_ok) begin
                drive_bit(1'b0, $urandom_range(0, 100));
                drive_bit(1'b1, D);
            end
            if ($urandom_range(0, 2) != 0) drive_bit(1'b1, $urandom_range(1, 60));
        end
        drive_bit(1'b1, 3 * D);
        check("end_busy", busy, 0);

        lim_end    = cyc;
        model_data = 8'h00;
        model(0, rst_edge);
        for (int i = rst_edge - 3; i < rst_edge; i++) line[i] = 1'b1;
        model_data = 8'h00;
        model(rst_edge - 2, lim_end);

        check("ev_count", dut_q.size(), mdl_q.size());
        n = (dut_q.size() < mdl_q.size()) ? dut_q.size() : mdl_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("ev%0d_kind", i), dut_q[i].kind, mdl_q[i].kind);
            check($sformatf("ev%0d_val", i),  dut_q[i].v, mdl_q[i].v);
            check($sformatf("ev%0d_cyc", i),  near(dut_q[i].c, mdl_q[i].c), mdl_q[i].c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
